// File: rtl/fpu_op_sequencer.sv
// Sequences FPU operations: a 2-entry request FIFO feeds an issue/wait/response FSM
// that ignores a stale finish level for MIN_WAIT cycles and abandons an op after TIMEOUT.
module fpu_op_sequencer #(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  fpu_funct,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_o,
  input  logic        fpu_finish,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_op,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0]  MIN_WAIT_C = 8'(MIN_WAIT);
  localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [31:0] QNAN_C     = 32'h7FC0_0000;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [65:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_rdy_en;
  logic [7:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res_data;
  logic [1:0]  r_res_op;
  logic        r_res_err;
  logic        w_push;
  logic        w_pop;
  logic        w_capture;
  logic        w_timeout;
  logic        w_finish;

  assign req_ready = r_rdy_en & (r_count != 2'd2);
  assign w_push    = req_valid & req_ready;
  assign w_finish  = fpu_finish & (r_cnt >= MIN_WAIT_C);

  // NOTE: FIFO storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_op, req_a, req_b};
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_finish) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == TIMEOUT_C) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand registers load only on a pop, so they hold from ISSUE through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 8'd0;
      r_op       <= 2'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_res_data <= 32'd0;
      r_res_op   <= 2'd0;
      r_res_err  <= 1'b0;
    end else begin
      if (w_pop) {r_op, r_a, r_b} <= r_mem[r_rd_ptr];
      if (r_state == S_ISSUE)     r_cnt <= 8'd0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      if (w_capture) begin
        r_res_data <= fpu_o;
        r_res_op   <= r_op;
        r_res_err  <= 1'b0;
      end else if (w_timeout) begin
        r_res_data <= QNAN_C;
        r_res_op   <= r_op;
        r_res_err  <= 1'b1;
      end
    end
  end

  assign fpu_funct = r_op;
  assign fpu_a     = r_a;
  assign fpu_b     = r_b;
  assign res_valid = (r_state == S_RESP);
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_err   = r_res_err;
  assign busy      = (r_state != S_IDLE) | (r_count != 2'd0);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench: a transaction-timeline model predicts every output each cycle,
// with directed scenarios pinning latency, stale finish, timeout, backpressure and reset.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;

  localparam int          MIN_WAIT = 2;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          f;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [1:0]  fpu_funct;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_o = 32'd0;
  logic        fpu_finish = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic        res_err;
  logic        busy;

  fpu_op_sequencer #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_o(fpu_o), .fpu_finish(fpu_finish),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue of accepted requests plus a timeline for the op in flight.
  req_t        q[$];
  req_t        cur;
  bit          inflight = 1'b0;
  int          t = 0;
  int          c_cap = 0;
  bit          cap_err = 1'b0;
  logic [31:0] cap_data = 32'd0;
  logic [1:0]  exp_funct = 2'd0;
  logic [31:0] exp_a = 32'd0;
  logic [31:0] exp_b = 32'd0;
  bit          exp_ready, exp_busy, exp_valid;
  logic [31:0] exp_data;
  bit          chk_en = 1'b0;

  int          fin_noise = 0;
  bit          o_fixed_en = 1'b0;
  logic [31:0] o_fixed = 32'd0;
  int          next_f = 0;
  logic [1:0]  got_ops[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(exp_busy));
      check("res_valid", 32'(res_valid), 32'(exp_valid));
      check("fpu_funct", 32'(fpu_funct), 32'(exp_funct));
      check("fpu_a", fpu_a, exp_a);
      check("fpu_b", fpu_b, exp_b);
      if (exp_valid) begin
        check("res_data", res_data, exp_data);
        check("res_op", 32'(res_op), 32'(cur.op));
        check("res_err", 32'(res_err), 32'(cap_err));
      end
    end
  end

  // One clock cycle: drive the FPU side, publish expectations, then advance the model.
  task automatic step();
    int   ctr;
    bit   in_wait;
    bit   push;
    req_t nr;
    chk_en  = 1'b1;
    ctr     = t - 2;
    in_wait = inflight && (t >= 2) && (ctr <= c_cap);
    if (in_wait && ctr >= MIN_WAIT) fpu_finish = (ctr >= cur.f);
    else if (fin_noise == 2)        fpu_finish = 1'($urandom_range(0, 1));
    else                            fpu_finish = (fin_noise == 1);
    fpu_o = o_fixed_en ? o_fixed : $urandom();
    if (in_wait && ctr == c_cap) cap_data = fpu_o;
    exp_ready = (q.size() < 2);
    exp_busy  = inflight || (q.size() != 0);
    exp_valid = inflight && (t >= c_cap + 3);
    exp_data  = cap_err ? QNAN : cap_data;
    @(negedge clk);
    if (res_valid === 1'b1 && res_ready) got_ops.push_back(res_op);
    @(posedge clk);
    push = req_valid && exp_ready;
    if (inflight) begin
      if (exp_valid && res_ready) inflight = 1'b0;
      else t++;
    end else if (q.size() != 0) begin
      cur      = q.pop_front();
      inflight = 1'b1;
      t        = 1;
      c_cap    = (cur.f > MIN_WAIT) ? cur.f : MIN_WAIT;
      cap_err  = (c_cap > TIMEOUT);
      if (cap_err) c_cap = TIMEOUT;
      exp_funct = cur.op;
      exp_a     = cur.a;
      exp_b     = cur.b;
    end
    if (push) begin
      nr.op = req_op;
      nr.a  = req_a;
      nr.b  = req_b;
      nr.f  = next_f;
      q.push_back(nr);
    end
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", 32'(res_op), 0);
    check("rst_res_err", 32'(res_err), 0);
    check("rst_fpu_funct", 32'(fpu_funct), 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_fpu_b", fpu_b, 0);
    check("rst_busy", 32'(busy), 0);
    q.delete();
    inflight  = 1'b0;
    t         = 0;
    c_cap     = 0;
    cap_err   = 1'b0;
    cap_data  = 32'd0;
    exp_funct = 2'd0;
    exp_a     = 32'd0;
    exp_b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 32'(req_ready), 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int f);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    next_f    = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_edges, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < max_edges) begin
      step();
      n++;
    end
  endtask

  task automatic offer_for(input int cycles, input int f, output int accepted);
    accepted = 0;
    for (int i = 0; i < cycles; i++) begin
      req_valid = (accepted < 4);
      req_op    = 2'(accepted);
      req_a     = 32'h4000_0000 + 32'(accepted);
      req_b     = 32'h3F80_0000;
      next_f    = f;
      if (req_valid && req_ready) accepted++;
      step();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    do_reset();

    // Add with finish rising at counter 3.
    fin_noise = 0; o_fixed_en = 1'b1; o_fixed = 32'h4040_0000;
    send(2'd0, 32'h3F80_0000, 32'h4000_0000, 3);
    wait_valid(40, n);
    check("add_latency", n, 6);
    check("add_data", res_data, 32'h4040_0000);
    check("add_op", 32'(res_op), 0);
    check("add_err", 32'(res_err), 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("add_valid_drop", 32'(res_valid), 0);

    // Stale finish held high: capture exactly at counter MIN_WAIT.
    fin_noise = 1; o_fixed_en = 1'b0;
    send(2'd3, 32'h4000_0000, 32'h4040_0000, 0);
    wait_valid(40, n);
    check("stale_latency", n, 5);
    check("stale_funct", 32'(fpu_funct), 3);
    check("stale_fpu_a", fpu_a, 32'h4000_0000);
    check("stale_op", 32'(res_op), 3);
    check("stale_err", 32'(res_err), 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    fin_noise = 0;

    // Timeout with finish held low.
    send(2'd2, 32'h3F80_0000, 32'h0000_0000, 300);
    wait_valid(400, n);
    check("to_latency", n, 258);
    check("to_data", res_data, QNAN);
    check("to_err", 32'(res_err), 1);
    check("to_op", 32'(res_op), 2);
    res_ready = 1'b1; step(); res_ready = 1'b0;

    // Backpressure: 3 accepted while results are blocked, then drain in order.
    got_ops.delete();
    offer_for(20, 1, acc);
    check("bp_accepted", acc, 3);
    check("bp_ready_low", 32'(req_ready), 0);
    n = 0;
    while (got_ops.size() < 4 && n < 300) begin
      res_ready = ~res_ready;
      req_valid = (acc < 4);
      req_op    = 2'd3;
      req_a     = 32'h4000_0003;
      req_b     = 32'h3F80_0000;
      next_f    = 1;
      if (req_valid && req_ready) acc++;
      step();
      n++;
    end
    req_valid = 1'b0; res_ready = 1'b0;
    check("bp_count", got_ops.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < got_ops.size()) ? 32'(got_ops[i]) : 32'hFFFF_FFFF, i);

    // Reset mid-WAIT with two entries queued.
    offer_for(10, 100, acc);
    check("rw_accepted", acc, 3);
    do_reset();
    got_ops.delete();
    fin_noise = 0; o_fixed_en = 1'b1; o_fixed = 32'h4040_0000;
    send(2'd0, 32'h3F80_0000, 32'h4000_0000, 3);
    wait_valid(40, n);
    check("rw_latency", n, 6);
    check("rw_data", res_data, 32'h4040_0000);
    res_ready = 1'b1;
    repeat (30) step();
    check("rw_single_result", got_ops.size(), 1);

    // Randomized traffic against the model.
    fin_noise = 2; o_fixed_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      req_valid = ($urandom_range(0, 99) < 50);
      req_op    = 2'($urandom_range(0, 3));
      req_a     = $urandom();
      req_b     = $urandom();
      case ($urandom_range(0, 79))
        0:       next_f = 300;
        1:       next_f = TIMEOUT;
        2:       next_f = TIMEOUT - 1;
        default: next_f = $urandom_range(0, 7);
      endcase
      res_ready = ($urandom_range(0, 99) < 60);
      step();
    end

    req_valid = 1'b0; res_ready = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    check("drain_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
